// File: rtl/mem_io_bridge_pkg.sv
// Shared definitions for the load/store bridge.
// State codes, default IO window base, decode bundle.
package mem_io_bridge_pkg;

  localparam int ISA_W = 32;

  localparam logic [ISA_W-1:0] IO_BASE_DEF = 32'hFFFF_FC00;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_IO   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  typedef struct packed {
    logic       is_io;
    logic       unmapped;
    logic [3:0] ch;
  } io_dec_t;

endpackage

// File: rtl/mem_io_bridge_io_addr_decode.sv
// Address decoder: byte address -> IO region flag,
// unmapped flag and channel number.
module mem_io_bridge_io_addr_decode
  import mem_io_bridge_pkg::*;
#(
  parameter int               IO_CH     = 4,
  parameter logic [ISA_W-1:0] IO_BASE   = IO_BASE_DEF,
  parameter int               IO_STRIDE = 16
) (
  input  logic [ISA_W-1:0] addr,
  output io_dec_t          dec
);

  localparam int SH = $clog2(IO_STRIDE);

  logic [ISA_W-1:0] idx;

  assign idx = (addr - IO_BASE) >> SH;

  // Region flags and channel index from the window offset
  always_comb begin
    dec          = '0;
    dec.is_io    = addr >= IO_BASE;
    dec.unmapped = dec.is_io && (idx >= ISA_W'(IO_CH));
    dec.ch       = idx[3:0];
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Load/store bridge: CPU data path to data memory
// and memory-mapped IO channels with output latches.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int               DATA_W    = 32,
  parameter int               IO_W      = 16,
  parameter int               IO_CH     = 4,
  parameter logic [ISA_W-1:0] IO_BASE   = IO_BASE_DEF,
  parameter int               IO_STRIDE = 16,
  parameter int               MEM_LAT   = 1,
  parameter int               TIMEOUT   = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ISA_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ISA_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [IO_CH-1:0]      io_cs,
  output logic                  io_we,
  output logic [IO_W-1:0]       io_wdata,
  input  logic [IO_CH*IO_W-1:0] io_rdata,
  input  logic [IO_CH-1:0]      io_ready,
  output logic [IO_CH*IO_W-1:0] io_out
);

  localparam int CMAX = (MEM_LAT > TIMEOUT) ? MEM_LAT : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [ISA_W-1:0]      addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  we_q;
  logic [3:0]            ch_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic [IO_CH*IO_W-1:0] io_out_q;

  io_dec_t               dec;
  logic [IO_CH-1:0]      cs_oh;
  logic                  sel_ready;
  logic [IO_W-1:0]       rd_slice;

  mem_io_bridge_io_addr_decode #(
    .IO_CH     (IO_CH),
    .IO_BASE   (IO_BASE),
    .IO_STRIDE (IO_STRIDE)
  ) u_dec (
    .addr (req_addr),
    .dec  (dec)
  );

  assign cs_oh     = IO_CH'(1) << ch_q;
  assign sel_ready = |(io_ready & cs_oh);

  // Read slice of the captured channel
  always_comb begin
    rd_slice = '0;
    for (int c = 0; c < IO_CH; c++) begin
      if (ch_q == 4'(c)) begin
        rd_slice = io_rdata[c*IO_W +: IO_W];
      end
    end
  end

  assign req_ready = state == S_IDLE;
  assign rsp_valid = state == S_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_en    = (state == S_MEM) && (cnt == '0);
  assign mem_we    = (state == S_MEM) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign io_cs     = (state == S_IO) ? cs_oh : '0;
  assign io_we     = (state == S_IO) && we_q;
  assign io_wdata  = wdata_q[IO_W-1:0];
  assign io_out    = io_out_q;

  // Request FSM, shared latency/timeout counter, capture and latches
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ch_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      io_out_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_write;
            ch_q    <= dec.ch;
            unique case (1'b1)
              dec.unmapped: begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                state   <= S_RESP;
              end
              dec.is_io && !dec.unmapped: state <= S_IO;
              !dec.is_io:                 state <= S_MEM;
            endcase
          end
        end
        S_MEM: begin
          if (cnt == CW'(MEM_LAT - 1)) begin
            rdata_q <= we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
            cnt     <= '0;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IO: begin
          if (sel_ready) begin
            if (we_q) begin
              for (int c = 0; c < IO_CH; c++) begin
                if (ch_q == 4'(c)) begin
                  io_out_q[c*IO_W +: IO_W] <= wdata_q[IO_W-1:0];
                end
              end
            end
            rdata_q <= we_q ? '0 : DATA_W'(rd_slice);
            err_q   <= 1'b0;
            cnt     <= '0;
            state   <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            cnt     <= '0;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: state <= S_IDLE;
      endcase
    end
  end

endmodule
